tx_audio_frontend: RTL and testbench
====================================

# tx_audio_frontend

Audio capture and conditioning stage directly upstream of the transmit modulator core. It paces an external 12-bit ADC with a conversion-start strobe and captures offset-binary codes. Each code is converted to two's complement, DC offset is removed with a first-order tracker, and a Q2.2 gain is applied with saturation. The result is held as the signed 12-bit sample the modulator consumes on every clock.

## Interface

Parameters:
- `DIV`, default 8: clock cycles per sample period. Must be ≥ 4.
- `DC_SHIFT`, default 4: DC tracker time constant k; the tracker weight is 2^-k.

Ports:
- `clock`, input, 1: system clock. One clock domain.
- `reset`, input, 1: synchronous, active-high.
- `io_adc_data`, input, 12: ADC code in offset binary (0x800 = zero).
- `io_adc_valid`, input, 1: `io_adc_data` is valid this cycle.
- `io_adc_convst`, output, 1: conversion start, one cycle wide, once per period.
- `io_gain`, input, 4: unsigned Q2.2 gain. 4 = unity; range 0–3.75.
- `io_dc_en`, input, 1: 1 = subtract the tracked DC; 0 = bypass the tracker.
- `io_out_value`, output, 12: signed conditioned sample, held between updates.
- `io_out_valid`, output, 1: one-cycle pulse when `io_out_value` updates.
- `io_clip`, output, 1: the current `io_out_value` was saturated.
- `io_overrun`, output, 1: sticky flag. Set when more than one ADC sample arrives in a period.

## Operation

- **Period counter `cnt`:**
  - Range 0..DIV-1, increments every cycle, wraps DIV-1 → 0, reset to 0.
  - `io_adc_convst` = (cnt == 0) && !reset.
- **Stage 1 (capture):**
  - On `io_adc_valid`: s = {~io_adc_data[11], io_adc_data[10:0]}, signed 12 bits (s = code − 2048).
- **Stage 2 (DC):**
  - dc = acc >>> k, arithmetic shift.
  - y = s − (io_dc_en ? dc : 0), 13-bit signed.
  - acc ← acc + s − dc.
  - acc is signed, 12+k bits, reset 0.
  - acc updates on every valid sample regardless of `io_dc_en`.
- **Stage 3 (gain/saturate):**
  - p = y × gain, 17-bit signed.
  - q = p >>> 2, flooring.
  - Saturate to [−2048, 2047] into `io_out_value`.
  - `io_clip` = saturation occurred. It is registered with the value and holds with it.
- **Overrun rule:**
  - A valid arriving while a valid has already been seen since the last convst sets `io_overrun`.
  - A valid in the same cycle as convst starts the new period and is not an overrun.
  - Every valid is still processed; the later sample wins.
  - `io_overrun` is cleared only by reset.
- `io_gain` and `io_dc_en` are sampled in the cycle the sample enters the stage that uses them. No shadowing.

## Timing

- **Reset values:** `io_adc_convst` 0, `io_out_value` 0, `io_out_valid` 0, `io_clip` 0, `io_overrun` 0. Pipeline valids, acc and cnt are all cleared.
- **First convst:** the first cycle after reset deasserts. Then every DIV cycles.
- **Latency:** `io_adc_valid` in cycle t gives `io_out_valid` in cycle t+3. Fully pipelined; back-to-back valids are accepted.
- **Hold:** `io_out_value` is stable between `io_out_valid` pulses, i.e. a zero-order hold at the clock rate.
- **Reset mid-operation:** in-flight samples are discarded, no `io_out_valid` is emitted for them, and the tracker restarts from 0.

## Structure

- **Shared package `tx_audio_pkg`:**
  - `SAMPLE_W` = 12, `GAIN_FRAC` = 2
  - `SAT_MAX` = 2047, `SAT_MIN` = −2048
  - Function `sat12`: signed saturate to 12 bits, returning value plus clip bit.
- **Sub-module `dc_tracker`:**
  - Inputs: `clock`, `reset`, in_valid, s, dc_en, k parameter.
  - Outputs: out_valid, y.
  - One register stage.
- Counter, capture, gain and saturation remain in the top level.

## Test plan

1. **Reset and pacing:** DIV=8. Release reset, then `io_adc_convst` pulses at cycles 1, 9, 17 after release. All outputs are 0 during reset and until the first result.
2. **DC bypass:** `io_dc_en`=0, gain=4, code 0xC00 each period. `io_out_value`=1024 with `io_out_valid` 3 cycles after each valid; `io_clip`=0.
3. **DC tracking:** k=4, `io_dc_en`=1, gain=4, constant 0xC00.
   - Outputs are 1024, 960, 900, … (y_n = 1024 − (acc_n >>> 4), with acc_1=1024, acc_2=1984).
   - Outputs decrease monotonically toward 0.
4. **Saturation:** `io_dc_en`=0, gain=15.
   - Code 0xFFF gives 2047 with clip=1.
   - Code 0x000 gives −2048 with clip=1.
   - Code 0x801 (s=1) gives 3, clip=0.
   - Gain=1 with code 0x7FD (s=−3) gives −1 (floor).
5. **Overrun:**
   - Two valids in one period set `io_overrun`, and the second sample appears at the output.
   - A valid coincident with convst does not set it.
   - The flag persists until reset.
6. **Reset mid-pipeline:**
   - Assert reset 1 cycle after a valid. No `io_out_valid` follows, and the output is 0.
   - After release, the next sample 0xC00 with `io_dc_en`=1 outputs 1024, confirming the tracker was cleared.

Source files
------------

// File: rtl/tx_audio_pkg.sv
// Shared widths, saturation limits and the 12-bit saturate helper for the
// transmit audio front end.
package tx_audio_pkg;

   localparam int SAMPLE_W  = 12;
   localparam int GAIN_FRAC = 2;
   localparam int SAT_MAX   = 2047;
   localparam int SAT_MIN   = -2048;

   typedef struct packed {
      logic signed [SAMPLE_W-1:0] value;
      logic                       clip;
   } sat_t;

   function automatic sat_t sat12(input logic signed [16:0] v);
      sat_t r;
      if (v > 17'(SAT_MAX)) begin
         r.value = 12'(SAT_MAX);
         r.clip  = 1'b1;
      end else if (v < 17'(SAT_MIN)) begin
         r.value = 12'(SAT_MIN);
         r.clip  = 1'b1;
      end else begin
         r.value = v[SAMPLE_W-1:0];
         r.clip  = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/tx_audio_frontend_dc_tracker.sv
// First-order DC tracker: subtracts acc >>> K from the sample and leaks the
// residual back into acc. One register stage.
module dc_tracker #(
   parameter int K = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   input  logic signed [11:0] s,
   input  logic               dc_en,
   output logic               out_valid,
   output logic signed [12:0] y
);

   localparam int ACC_W = 12 + K;

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_next;
   logic signed [11:0]      dc;
   logic signed [12:0]      y_next;

   // acc stays within s * 2^K, so the shifted value always fits 12 bits.
   assign dc       = acc[ACC_W-1:K];
   assign y_next   = {s[11], s} - (dc_en ? {dc[11], dc} : 13'd0);
   assign acc_next = acc + ACC_W'(s) - ACC_W'(dc);

   always_ff @(posedge clock) begin
      if (reset) begin
         acc       <= '0;
         y         <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            y   <= y_next;
            acc <= acc_next;
         end
      end
   end

endmodule

// File: rtl/tx_audio_frontend.sv
// ADC pacing, capture, DC removal, Q2.2 gain and saturation feeding the
// transmit modulator with a held signed 12-bit sample.
module tx_audio_frontend
   import tx_audio_pkg::*;
#(
   parameter int DIV      = 8,
   parameter int DC_SHIFT = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] io_adc_data,
   input  logic        io_adc_valid,
   output logic        io_adc_convst,
   input  logic [3:0]  io_gain,
   input  logic        io_dc_en,
   output logic [11:0] io_out_value,
   output logic        io_out_valid,
   output logic        io_clip,
   output logic        io_overrun
);

   localparam int CNT_W = $clog2(DIV);

   logic [CNT_W-1:0]   cnt;
   logic               period_start;
   logic               seen;
   logic               cap_valid;
   logic signed [11:0] cap_s;
   logic               dc_valid;
   logic signed [12:0] dc_y;
   logic signed [16:0] y_ext;
   logic signed [16:0] gain_ext;
   logic signed [16:0] prod;
   logic signed [16:0] q;
   sat_t               sat;

   assign period_start  = (cnt == '0);
   assign io_adc_convst = period_start && !reset;

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt <= '0;
      end else if (cnt == CNT_W'(DIV - 1)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // A valid on the convst cycle opens a new period rather than colliding.
   always_ff @(posedge clock) begin
      if (reset) begin
         seen       <= 1'b0;
         io_overrun <= 1'b0;
      end else if (io_adc_valid) begin
         if (!period_start && seen) io_overrun <= 1'b1;
         seen <= 1'b1;
      end else if (period_start) begin
         seen <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cap_valid <= 1'b0;
         cap_s     <= '0;
      end else begin
         cap_valid <= io_adc_valid;
         if (io_adc_valid) cap_s <= {~io_adc_data[11], io_adc_data[10:0]};
      end
   end

   dc_tracker #(
      .K (DC_SHIFT)
   ) u_dc_tracker (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (cap_valid),
      .s         (cap_s),
      .dc_en     (io_dc_en),
      .out_valid (dc_valid),
      .y         (dc_y)
   );

   assign y_ext    = 17'(dc_y);
   assign gain_ext = {13'd0, io_gain};
   assign prod     = y_ext * gain_ext;
   assign q        = prod >>> GAIN_FRAC;
   assign sat      = sat12(q);

   always_ff @(posedge clock) begin
      if (reset) begin
         io_out_value <= '0;
         io_clip      <= 1'b0;
         io_out_valid <= 1'b0;
      end else begin
         io_out_valid <= dc_valid;
         if (dc_valid) begin
            io_out_value <= sat.value;
            io_clip      <= sat.clip;
         end
      end
   end

endmodule

// File: tb/tb_tx_audio_frontend.sv
// Directed bench for tx_audio_frontend (DIV=8, DC_SHIFT=4).
module tb_tx_audio_frontend;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] io_adc_data = 12'h000;
   logic        io_adc_valid = 1'b0;
   logic        io_adc_convst;
   logic [3:0]  io_gain = 4'd4;
   logic        io_dc_en = 1'b0;
   logic [11:0] io_out_value;
   logic        io_out_valid;
   logic        io_clip;
   logic        io_overrun;

   int passed = 0;
   int total = 0;
   int ov_count = 0;

   tx_audio_frontend #(
      .DIV      (8),
      .DC_SHIFT (4)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .io_adc_data   (io_adc_data),
      .io_adc_valid  (io_adc_valid),
      .io_adc_convst (io_adc_convst),
      .io_gain       (io_gain),
      .io_dc_en      (io_dc_en),
      .io_out_value  (io_out_value),
      .io_out_valid  (io_out_valid),
      .io_clip       (io_clip),
      .io_overrun    (io_overrun)
   );

   initial forever #5 clock = ~clock;

   always @(negedge clock) if (io_out_valid) ov_count++;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      io_adc_valid = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
   endtask

   task automatic wait_convst(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (io_adc_convst) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // Sends one code on a convst cycle and reports the first result and its latency.
   task automatic run_sample(input logic [11:0] code, output logic [11:0] val,
                             output logic clp, output int lat);
      bit ok;
      val = 12'h000;
      clp = 1'b0;
      lat = -1;
      wait_convst(ok);
      if (!ok) return;
      io_adc_data  = code;
      io_adc_valid = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clock);
         #1;
         io_adc_valid = 1'b0;
         #3;
         if (io_out_valid && lat < 0) begin
            lat = c;
            val = io_out_value;
            clp = io_clip;
         end
      end
      tick();
   endtask

   task automatic test_reset();
      logic [19:0] seen_cs;
      logic        any_out;
      reset = 1'b1;
      repeat (3) tick();
      #3;
      total++;
      if (io_adc_convst !== 1'b0) $display("FAIL reset_convst: got %b want 0", io_adc_convst);
      else passed++;
      total++;
      if ({io_out_value, io_out_valid, io_clip, io_overrun} !== 15'd0)
         $display("FAIL reset_outputs: got value=%h valid=%b clip=%b ovr=%b want all 0",
                  io_out_value, io_out_valid, io_clip, io_overrun);
      else passed++;
      tick();
      reset = 1'b0;
      seen_cs = '0;
      any_out = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #3;
         seen_cs[i] = io_adc_convst;
         any_out = any_out | io_out_valid | io_clip | io_overrun | (io_out_value != 12'h000);
         tick();
      end
      total++;
      if (seen_cs !== 20'h10101) $display("FAIL convst_pacing: got %h want 10101", seen_cs);
      else passed++;
      total++;
      if (any_out !== 1'b0) $display("FAIL idle_outputs: got activity %b want 0", any_out);
      else passed++;
   endtask

   task automatic test_dc_bypass();
      logic [11:0] val;
      logic        clp;
      int          lat;
      io_dc_en = 1'b0;
      io_gain  = 4'd4;
      for (int k = 0; k < 3; k++) begin
         run_sample(12'hC00, val, clp, lat);
         total++;
         if (lat !== 3) $display("FAIL bypass_latency[%0d]: got %0d want 3", k, lat);
         else passed++;
         total++;
         if (val !== 12'h400) $display("FAIL bypass_value[%0d]: got %h want 400", k, val);
         else passed++;
         total++;
         if (clp !== 1'b0) $display("FAIL bypass_clip[%0d]: got %b want 0", k, clp);
         else passed++;
      end
      repeat (5) tick();
      #3;
      total++;
      if (io_out_value !== 12'h400 || io_out_valid !== 1'b0)
         $display("FAIL hold: got value=%h valid=%b want 400/0", io_out_value, io_out_valid);
      else passed++;
      tick();
   endtask

   task automatic test_dc_tracking();
      logic [11:0] exp_y [6] = '{12'h400, 12'h3C0, 12'h384, 12'h34C, 12'h317, 12'h2E6};
      logic [11:0] val;
      logic        clp;
      int          lat;
      do_reset();
      io_dc_en = 1'b1;
      io_gain  = 4'd4;
      for (int k = 0; k < 6; k++) begin
         run_sample(12'hC00, val, clp, lat);
         total++;
         if (lat !== 3 || val !== exp_y[k])
            $display("FAIL dc_track[%0d]: got value=%h lat=%0d want %h lat=3", k, val, lat, exp_y[k]);
         else passed++;
      end
   endtask

   task automatic test_saturation();
      logic [11:0] codes [6] = '{12'hFFF, 12'h000, 12'h801, 12'h7FD, 12'h7FF, 12'hC00};
      logic [3:0]  gains [6] = '{4'd15, 4'd15, 4'd15, 4'd1, 4'd2, 4'd0};
      logic [11:0] expv  [6] = '{12'h7FF, 12'h800, 12'h003, 12'hFFF, 12'hFFF, 12'h000};
      logic        expc  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [11:0] val;
      logic        clp;
      int          lat;
      io_dc_en = 1'b0;
      for (int k = 0; k < 6; k++) begin
         io_gain = gains[k];
         run_sample(codes[k], val, clp, lat);
         total++;
         if (lat !== 3 || val !== expv[k] || clp !== expc[k])
            $display("FAIL sat[%0d]: got value=%h clip=%b lat=%0d want %h clip=%b lat=3",
                     k, val, clp, lat, expv[k], expc[k]);
         else passed++;
      end
   endtask

   task automatic test_overrun();
      logic [11:0] val;
      logic        clp;
      int          lat;
      bit          ok;
      do_reset();
      io_dc_en = 1'b0;
      io_gain  = 4'd4;
      run_sample(12'h900, val, clp, lat);
      run_sample(12'h900, val, clp, lat);
      total++;
      if (io_overrun !== 1'b0) $display("FAIL ovr_coincident: got %b want 0", io_overrun);
      else passed++;
      wait_convst(ok);
      tick();
      io_adc_data  = 12'h900;
      io_adc_valid = 1'b1;
      tick();
      io_adc_valid = 1'b0;
      repeat (3) tick();
      total++;
      if (!ok || io_overrun !== 1'b0) $display("FAIL ovr_first_late: got %b want 0", io_overrun);
      else passed++;
      io_adc_data  = 12'hA00;
      io_adc_valid = 1'b1;
      tick();
      io_adc_valid = 1'b0;
      repeat (2) tick();
      #3;
      total++;
      if (io_out_valid !== 1'b1 || io_out_value !== 12'h200)
         $display("FAIL ovr_second_wins: got value=%h valid=%b want 200/1", io_out_value, io_out_valid);
      else passed++;
      total++;
      if (io_overrun !== 1'b1) $display("FAIL ovr_set: got %b want 1", io_overrun);
      else passed++;
      tick();
      run_sample(12'h900, val, clp, lat);
      run_sample(12'h900, val, clp, lat);
      total++;
      if (io_overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", io_overrun);
      else passed++;
      do_reset();
      total++;
      if (io_overrun !== 1'b0) $display("FAIL ovr_reset_clear: got %b want 0", io_overrun);
      else passed++;
   endtask

   task automatic test_reset_mid_pipeline();
      logic [11:0] val;
      logic        clp;
      int          lat;
      int          n0;
      bit          ok;
      do_reset();
      io_dc_en = 1'b1;
      io_gain  = 4'd4;
      run_sample(12'hC00, val, clp, lat);
      total++;
      if (val !== 12'h400) $display("FAIL midrst_pre: got %h want 400", val);
      else passed++;
      wait_convst(ok);
      n0 = ov_count;
      io_adc_data  = 12'hC00;
      io_adc_valid = 1'b1;
      tick();
      io_adc_valid = 1'b0;
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      repeat (4) tick();
      total++;
      if (!ok || ov_count !== n0) $display("FAIL midrst_no_valid: got %0d pulses want 0", ov_count - n0);
      else passed++;
      total++;
      if (io_out_value !== 12'h000) $display("FAIL midrst_value: got %h want 000", io_out_value);
      else passed++;
      run_sample(12'hC00, val, clp, lat);
      total++;
      if (lat !== 3 || val !== 12'h400)
         $display("FAIL midrst_tracker_clear: got value=%h lat=%0d want 400 lat=3", val, lat);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_dc_bypass();
      test_dc_tracking();
      test_saturation();
      test_overrun();
      test_reset_mid_pipeline();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
